// File: rtl/maze_mem_arbiter_if.sv
// maze_mem_arbiter_if: requester ports plus memory-side bus of the maze memory arbiter
interface maze_mem_arbiter_if #(parameter int MAZE_WIDTH = 6);
    logic                  req0, req1, we0, we1;
    logic [MAZE_WIDTH-1:0] row0, row1, col0, col1;
    logic                  gnt0, gnt1, rvalid0, rvalid1, rdata;
    logic [MAZE_WIDTH-1:0] mem_row, mem_col;
    logic                  mem_oe, mem_we, mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, row0, row1, col0, col1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_row, mem_col, mem_oe, mem_we
    );

    modport master (
        output req0, req1, we0, we1, row0, row1, col0, col1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_row, mem_col, mem_oe, mem_we
    );
endinterface

// File: rtl/maze_mem_arbiter.sv
// maze_mem_arbiter: round-robin, burst-bounded sharing of the single-port maze memory
module maze_mem_arbiter #(
    parameter int MAZE_WIDTH = 6,
    parameter int MAX_BURST  = 8,
    parameter int CNT_WIDTH  = 4
) (
    input logic               clk,
    input logic               rst_n,
    maze_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_BURST - 1);
    state_t               state, state_nx;
    logic                 last, gnt0, gnt1, other_req, at_limit;
    logic [CNT_WIDTH-1:0] burst_cnt;

    assign gnt0      = state == OWN0 && bus.req0;
    assign gnt1      = state == OWN1 && bus.req1;
    assign other_req = state == OWN0 ? bus.req1 : state == OWN1 ? bus.req0 : 1'b0;
    assign at_limit  = burst_cnt == CNT_MAX;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.req0 && bus.req1 ? (last ? OWN0 : OWN1) :
                                bus.req0 ? OWN0 : bus.req1 ? OWN1 : IDLE;
            OWN0:    state_nx = !bus.req0 ? (bus.req1 ? OWN1 : IDLE) :
                                bus.req1 && at_limit ? OWN1 : OWN0;
            OWN1:    state_nx = !bus.req1 ? (bus.req0 ? OWN0 : IDLE) :
                                bus.req0 && at_limit ? OWN0 : OWN1;
            default: state_nx = IDLE;
        endcase
    end

    // the burst count only advances while the other port is kept waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            burst_cnt   <= '0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
        end else begin
            state       <= state_nx;
            last        <= gnt0 ? 1'b0 : gnt1 ? 1'b1 : last;
            burst_cnt   <= state_nx != state || !other_req ? '0 :
                           (gnt0 || gnt1) && !at_limit ? burst_cnt + CNT_WIDTH'(1) : burst_cnt;
            bus.rvalid0 <= gnt0 && !bus.we0;
            bus.rvalid1 <= gnt1 && !bus.we1;
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.mem_row = gnt0 ? bus.row0 : gnt1 ? bus.row1 : {MAZE_WIDTH{1'b0}};
    assign bus.mem_col = gnt0 ? bus.col0 : gnt1 ? bus.col1 : {MAZE_WIDTH{1'b0}};
    assign bus.mem_we  = (gnt0 && bus.we0) || (gnt1 && bus.we1);
    assign bus.mem_oe  = (gnt0 && !bus.we0) || (gnt1 && !bus.we1);
    assign bus.rdata   = bus.mem_rdata;
endmodule
